// File: rtl/regfile_mp.sv
// Multi-port flop-based register file: NW byte-masked write ports, NR registered
// read ports with valid strobes, write-first bypass, synchronous clear.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int N        = 32,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(N),
    localparam int NB      = WIDTH / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NR*AW-1:0]    R_addr,
    input  logic [NR-1:0]       R_en,
    output logic [NR*WIDTH-1:0] R_data,
    output logic [NR-1:0]       R_valid,
    input  logic [NW*AW-1:0]    W_addr,
    input  logic [NW-1:0]       W_en,
    input  logic [NW*NB-1:0]    W_be,
    input  logic [NW*WIDTH-1:0] W_data
);

    logic [WIDTH-1:0] mem      [N];
    logic [WIDTH-1:0] mem_next [N];
    logic [WIDTH-1:0] rd_word  [NR];

    // An address is "live" when it maps to a real, writable entry.
    function automatic logic live(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(N)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Post-edge array image; ascending port order makes the highest port win per byte.
    always_comb begin
        mem_next = mem;
        for (int w = 0; w < NW; w++) begin
            if (W_en[w] && live(W_addr[w*AW +: AW])) begin
                for (int b = 0; b < NB; b++) begin
                    if (W_be[w*NB + b]) begin
                        mem_next[W_addr[w*AW +: AW]][b*8 +: 8] = W_data[w*WIDTH + b*8 +: 8];
                    end
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                mem_next[i] = '0;
            end
        end
    end

    // Reads sample the post-edge image, which gives write-first bypass for free.
    always_comb begin
        for (int r = 0; r < NR; r++) begin
            rd_word[r] = '0;
            if (live(R_addr[r*AW +: AW])) begin
                rd_word[r] = mem_next[R_addr[r*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= mem_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_data  <= '0;
            R_valid <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                R_valid[r] <= R_en[r];
                if (R_en[r]) begin
                    R_data[r*WIDTH +: WIDTH] <= rd_word[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: dut_a (N=32) and dut_b (N=24, ZERO_REG=1),
// expected read words queued at issue and checked by a valid-driven monitor.
module tb_regfile_mp;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_clr, b_clr;
  logic [9:0]  a_raddr, b_raddr;
  logic [1:0]  a_ren, b_ren;
  logic [63:0] a_rdata, b_rdata;
  logic [1:0]  a_rvalid, b_rvalid;
  logic [9:0]  a_waddr, b_waddr;
  logic [1:0]  a_wen, b_wen;
  logic [7:0]  a_wbe, b_wbe;
  logic [63:0] a_wdata, b_wdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a0[$];
  logic [31:0] exp_a1[$];
  logic [31:0] exp_b0[$];
  logic [31:0] exp_b1[$];

  regfile_mp #(.WIDTH(32), .N(32), .NR(2), .NW(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr),
    .R_addr(a_raddr), .R_en(a_ren), .R_data(a_rdata), .R_valid(a_rvalid),
    .W_addr(a_waddr), .W_en(a_wen), .W_be(a_wbe), .W_data(a_wdata)
  );

  regfile_mp #(.WIDTH(32), .N(24), .NR(2), .NW(2), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .R_addr(b_raddr), .R_en(b_ren), .R_data(b_rdata), .R_valid(b_rvalid),
    .W_addr(b_waddr), .W_en(b_wen), .W_be(b_wbe), .W_data(b_wdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    a_clr = 1'b0; b_clr = 1'b0;
    a_ren = '0; b_ren = '0; a_wen = '0; b_wen = '0;
    a_wbe = '0; b_wbe = '0;
  endtask

  task automatic wr(input int d, input int p, input logic [4:0] a,
                    input logic [31:0] v, input logic [3:0] be);
    if (d == 0) begin
      a_waddr[p*AW +: AW] = a; a_wdata[p*32 +: 32] = v;
      a_wbe[p*4 +: 4] = be; a_wen[p] = 1'b1;
    end else begin
      b_waddr[p*AW +: AW] = a; b_wdata[p*32 +: 32] = v;
      b_wbe[p*4 +: 4] = be; b_wen[p] = 1'b1;
    end
  endtask

  task automatic rd(input int d, input int p, input logic [4:0] a, input logic [31:0] e);
    if (d == 0) begin
      a_raddr[p*AW +: AW] = a; a_ren[p] = 1'b1;
      if (p == 0) exp_a0.push_back(e); else exp_a1.push_back(e);
    end else begin
      b_raddr[p*AW +: AW] = a; b_ren[p] = 1'b1;
      if (p == 0) exp_b0.push_back(e); else exp_b1.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // scoreboard monitor
  task automatic mon(input int id, input logic v, input logic [31:0] d);
    logic [31:0] e;
    int n;
    if (v !== 1'b1) return;
    case (id)
      0: n = exp_a0.size();
      1: n = exp_a1.size();
      2: n = exp_b0.size();
      default: n = exp_b1.size();
    endcase
    if (n == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_valid stream %0d: got valid with data %08h, required no valid", id, d);
    end else begin
      case (id)
        0: e = exp_a0.pop_front();
        1: e = exp_a1.pop_front();
        2: e = exp_b0.pop_front();
        default: e = exp_b1.pop_front();
      endcase
      chk($sformatf("read_data_stream%0d", id), d, e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_rvalid[0], a_rdata[31:0]);
    mon(1, a_rvalid[1], a_rdata[63:32]);
    mon(2, b_rvalid[0], b_rdata[31:0]);
    mon(3, b_rvalid[1], b_rdata[63:32]);
  end

  initial begin
    clear_inputs();
    a_raddr = '0; b_raddr = '0; a_waddr = '0; b_waddr = '0;
    a_wdata = '0; b_wdata = '0;

    // reset state
    #12;
    chk("reset_rdata_a", a_rdata[31:0], 32'h0);
    chk("reset_rvalid_a", {30'b0, a_rvalid}, 32'h0);
    chk("reset_rdata_b", b_rdata[63:32], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // reset contents read back
    rd(0, 0, 5'd5, 32'h0);
    tick();

    // byte mask
    wr(0, 0, 5'd3, 32'hAABBCCDD, 4'b1111); tick();
    wr(0, 0, 5'd3, 32'h11223344, 4'b0101); tick();
    rd(0, 0, 5'd3, 32'hAA22CC44); tick();

    // per-byte conflict plus write-first bypass on both read ports
    wr(0, 0, 5'd7, 32'h01010101, 4'b1111);
    wr(0, 1, 5'd7, 32'h02020202, 4'b0011);
    rd(0, 0, 5'd7, 32'h01010202);
    rd(0, 1, 5'd7, 32'h01010202);
    tick();
    rd(0, 0, 5'd7, 32'h01010202); tick();

    // hold with R_en low while the entry is overwritten
    rd(0, 0, 5'd3, 32'hAA22CC44); tick();
    for (int i = 0; i < 3; i++) begin
      wr(0, 0, 5'd3, 32'h0, 4'b1111);
      tick();
      chk("hold_rdata", a_rdata[31:0], 32'hAA22CC44);
      chk("hold_rvalid", {31'b0, a_rvalid[0]}, 32'h0);
    end
    // all-zero byte enables are ignored
    wr(0, 1, 5'd3, 32'hFFFFFFFF, 4'b0000); tick();
    rd(0, 0, 5'd3, 32'h0); tick();

    // ZERO_REG entry and out-of-range address on dut_b
    wr(1, 0, 5'd0, 32'hFFFFFFFF, 4'b1111);
    wr(1, 1, 5'd30, 32'hFFFFFFFF, 4'b1111);
    rd(1, 0, 5'd0, 32'h0);
    tick();
    rd(1, 0, 5'd0, 32'h0);
    rd(1, 1, 5'd30, 32'h0);
    tick();
    rd(1, 0, 5'd6, 32'h0); tick();
    wr(1, 0, 5'd23, 32'h5, 4'b1111); tick();
    rd(1, 1, 5'd23, 32'h5); tick();

    // fill, then clear with a simultaneous write/read
    for (int i = 0; i < 16; i++) begin
      wr(0, 0, 5'(i), 32'hA5000000 | i, 4'b1111);
      wr(0, 1, 5'(i + 16), 32'hA5000000 | (i + 16), 4'b1111);
      tick();
    end
    rd(0, 0, 5'd9, 32'hA5000009);
    rd(0, 1, 5'd20, 32'hA5000014);
    tick();
    a_clr = 1'b1;
    wr(0, 0, 5'd9, 32'hDEADBEEF, 4'b1111);
    rd(0, 0, 5'd9, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      rd(0, 0, 5'(i), 32'h0);
      rd(0, 1, 5'(i + 16), 32'h0);
      tick();
    end
    // clr held across two edges with writes keeps the array zero
    a_clr = 1'b1; wr(0, 1, 5'd12, 32'h12121212, 4'b1111); tick();
    a_clr = 1'b1; wr(0, 1, 5'd12, 32'h34343434, 4'b1111); tick();
    rd(0, 0, 5'd12, 32'h0); tick();

    // async reset with a read in flight
    wr(0, 0, 5'd4, 32'h12345678, 4'b1111); tick();
    rd(0, 0, 5'd4, 32'h12345678); tick();
    @(negedge clk);
    a_raddr[4:0] = 5'd4;
    a_ren[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rdata", a_rdata[31:0], 32'h0);
    chk("async_reset_rvalid", {30'b0, a_rvalid}, 32'h0);
    a_ren = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    rd(0, 0, 5'd4, 32'h0); tick();

    // drain and final accounting
    tick(); tick();
    #6;
    chk("pending_reads_a0", 32'(exp_a0.size()), 32'h0);
    chk("pending_reads_a1", 32'(exp_a1.size()), 32'h0);
    chk("pending_reads_b0", 32'(exp_b0.size()), 32'h0);
    chk("pending_reads_b1", 32'(exp_b1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the energy-characterisation block set. It generalises the single read/write port array to NR read ports and NW write ports. Additions are:
- per-byte write enables
- registered read data with a valid strobe
- write-first bypass
- synchronous bulk clear
- optional hardwired-zero entry 0

It is used standalone as a characterisation target and as the storage core for datapath experiments.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
N, 32, number of entries (≥2, power of 2 not required)
NR, 2, number of read ports (≥1)
NW, 2, number of write ports (≥1)
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
AW (derived, not overridable), $clog2(N), address width
NB (derived), WIDTH/8, byte lanes per word

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of whole array
R_addr  input  NR*AW  read addresses; port r uses bits [r*AW +: AW]
R_en  input  NR  read enables, one per port
R_data  output  NR*WIDTH  registered read data; port r uses bits [r*WIDTH +: WIDTH]
R_valid  output  NR  high for one cycle when R_data[r] was updated by a read
W_addr  input  NW*AW  write addresses; port w uses bits [w*AW +: AW]
W_en  input  NW  write enables
W_be  input  NW*NB  byte enables; bit w*NB+b covers byte b of port w
W_data  input  NW*WIDTH  write data

Behaviour:
- Reset (rst_n low, asynchronous):
  - all N entries are set to 0
  - every R_data is set to 0 and every R_valid to 0
  - this holds while rst_n is low and is independent of clk
  - reset mid-operation discards any read in flight; no R_valid is asserted for it.
- Write: on a rising edge with W_en[w]=1 and clr=0, byte b of entry W_addr[w] takes W_data[w] byte b when W_be[w][b]=1. Unmasked bytes keep their value.
- Write conflict: when several ports write the same address, the highest-numbered port with its byte enable set wins, resolved per byte lane.
- Write exclusions — these writes are ignored with no side effect:
  - W_en=1 with W_be all zero
  - address ≥ N
  - address 0 when ZERO_REG=1
- Read latency is 1 cycle:
  - R_en[r]=1 at edge k causes R_data[r] to present the entry contents at edge k+1, and R_valid[r]=1 during cycle k+1.
  - When R_en[r]=0, R_data[r] holds its previous value and R_valid[r]=0. It never goes X.
- Bypass (write-first): if a write in the same cycle targets R_addr[r], the returned word is the post-write value. Per byte, this is the winning writer's byte if enabled, otherwise the stored byte. This exactly equals the array contents after the edge.
- Read exceptions:
  - address ≥ N returns 0 with R_valid=1
  - address 0 with ZERO_REG=1 returns 0
- Clear: clr=1 at an edge zeroes all entries.
  - Writes in that cycle are dropped (clr has priority).
  - Reads in that cycle return 0 with R_valid=1.
  - clr held for multiple cycles keeps the array at zero.
- Read ports are fully independent. Any number of ports may read the same address, including one being written.
- No internal FSM beyond the per-port output registers. The array storage is flops (N*WIDTH), not a macro.

Test Plan:
- Reset/read: WIDTH=32, N=32. Assert rst_n=0, release, then read addr 5 on port 0 → R_data[0]=0x00000000 one cycle later with R_valid[0]=1; R_valid stays 0 before the read.
- Byte mask: write 0xAABBCCDD to addr 3 (be=1111), then 0x11223344 to addr 3 with be=0101 → read addr 3 returns 0xAA22CC44.
- Conflict and bypass, same edge:
  - stimulus: port 0 writes addr 7 = 0x01010101 with be=1111; port 1 writes addr 7 = 0x02020202 with be=0011; port 0 reads addr 7
  - required: R_data[0]=0x01010202 next cycle, and a later read returns the same.
- Hold/no-X: read addr 3 (0xAA22CC44), then R_en=0 for 3 cycles while writing addr 3 = 0 → R_data[0] stays 0xAA22CC44 and R_valid[0]=0 throughout.
- ZERO_REG=1, N=24:
  - write 0xFFFFFFFF to addr 0 and to addr 30 → reads of both return 0
  - write 0x5 to addr 23 → read returns 0x5.
- Clear and async reset:
  - fill all entries, assert clr with a simultaneous write to addr 9 and read of addr 9 → read returns 0, and all entries read 0 afterwards
  - drop rst_n mid-cycle after issuing a read → R_data=0 and R_valid=0 immediately, with no valid pulse after release.
